rsa_timing_probe: RTL and testbench

RSA_TIMING_PROBE -- requirements
Module: rsa_timing_probe

---
 rtl/rsa_timing_probe.sv | 182 ++++++++++++++++++
 tb/tb_rsa_timing_probe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_timing_probe.sv
// rsa_timing_probe
//   Measures the latency of an RSA decryptor, in clock cycles from its start
//   pulse to its finish pulse. Each completed measurement is queued together
//   with the decrypted message in a small first-word-fall-through FIFO.
//   Abandoned measurements (timeout) and dropped entries (FIFO full) raise
//   sticky flags until they are cleared.
//
// Parameters
//   CNT_W   : width of the latency counter and of the recorded latency
//   DEPTH   : number of FIFO entries (power of two, >= 2)
//   TIMEOUT : cycle count at which a running measurement is abandoned
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   dec_start  in   start pulse seen by the decryptor
//   dec_finish in   finish pulse from the decryptor
//   dec_m      in   decrypted message, valid with dec_finish
//   clr_flags  in   clears overflow / timeout
//   rd_ready   in   consumer accepts the head entry
//   rd_valid   out  FIFO non-empty
//   rd_cycles  out  latency of the head entry
//   rd_m       out  message of the head entry
//   count      out  FIFO occupancy
//   busy       out  measurement in progress
//   overflow   out  sticky: a finished measurement was dropped (FIFO full)
//   timeout    out  sticky: a measurement hit TIMEOUT
module rsa_timing_probe #(
    parameter int CNT_W   = 24,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_start,
    input  logic                     dec_finish,
    input  logic [15:0]              dec_m,
    input  logic                     clr_flags,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_cycles,
    output logic [15:0]              rd_m,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               timeout_q, timeout_d;

    logic [CNT_W-1:0]   mem_cycles_q [DEPTH];
    logic [15:0]        mem_m_q      [DEPTH];

    logic               push_req_s;
    logic               push_ok_s;
    logic               pop_s;
    logic               full_s;
    logic               timeout_evt_s;

    // Measurement FSM: start loads 1, each further cycle adds 1, so the value
    // held when finish is sampled equals the number of edges since start.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        push_req_s    = 1'b0;
        timeout_evt_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dec_start) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_MEASURE: begin
                // finish has priority over the timeout check and over a
                // coincident start
                if (dec_finish) begin
                    push_req_s = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
                    timeout_evt_s = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in
    // the same cycle.
    always_comb begin
        full_s    = (count_q == CW'(DEPTH));
        pop_s     = (count_q != CW'(0)) && rd_ready;
        push_ok_s = push_req_s && (!full_s || pop_s);
        wr_ptr_d  = push_ok_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_s     ? rd_ptr_q + PW'(1) : rd_ptr_q;
        if (push_ok_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_s && !push_ok_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Sticky flags: a set event in the same cycle as clr_flags wins.
    always_comb begin
        overflow_d = clr_flags ? 1'b0 : overflow_q;
        timeout_d  = clr_flags ? 1'b0 : timeout_q;
        if (push_req_s && !push_ok_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end
        if (timeout_evt_s) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_d;
        end
    end

    // State, counter, pointers and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_cycles_q[wr_ptr_q] <= cnt_q;
            mem_m_q[wr_ptr_q]      <= dec_m;
        end
    end

    assign rd_valid  = (count_q != CW'(0));
    assign rd_cycles = mem_cycles_q[rd_ptr_q];
    assign rd_m      = mem_m_q[rd_ptr_q];
    assign count     = count_q;
    assign busy      = (state_q == ST_MEASURE);
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rsa_timing_probe.sv
// Self-checking bench for rsa_timing_probe. Expected FIFO entries are pushed
// to a scoreboard queue when a finish pulse is driven and popped when the
// DUT presents them at its head. Inputs change and outputs are sampled on
// the falling edge.
module tb_rsa_timing_probe;

    localparam int CNT_W   = 24;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 120;

    logic               clk = 1'b0;
    logic               rst;
    logic               dec_start;
    logic               dec_finish;
    logic [15:0]        dec_m;
    logic               clr_flags;
    logic               rd_ready;
    logic               rd_valid;
    logic [CNT_W-1:0]   rd_cycles;
    logic [15:0]        rd_m;
    logic [2:0]         count;
    logic               busy;
    logic               overflow;
    logic               timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [15:0] m;
    } entry_t;

    entry_t exp_q[$];
    logic   exp_ovf = 1'b0;

    rsa_timing_probe #(
        .CNT_W   (CNT_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_start  (dec_start),
        .dec_finish (dec_finish),
        .dec_m      (dec_m),
        .clr_flags  (clr_flags),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_cycles  (rd_cycles),
        .rd_m       (rd_m),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare the DUT head against the scoreboard front (or emptiness).
    task automatic chk_head(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, ".valid0"}, 64'(rd_valid), 64'd0);
        end else begin
            chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
            chk({tag, ".cycles"}, 64'(rd_cycles), 64'(exp_q[0].cyc));
            chk({tag, ".m"}, 64'(rd_m), 64'(exp_q[0].m));
        end
    endtask

    task automatic drain_one(input string tag);
        chk_head(tag);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    endtask

    // One measurement of 'lat' cycles; optionally pop and/or clear flags in
    // the finish cycle. Called on a falling edge.
    task automatic measure(input int lat, input logic [15:0] m,
                           input bit pop_fin, input bit clr_fin, input string tag);
        dec_start = 1'b1;
        @(negedge clk);
        dec_start = 1'b0;
        chk({tag, ".busy1"}, 64'(busy), 64'd1);
        repeat (lat - 1) @(negedge clk);
        dec_finish = 1'b1;
        dec_m      = m;
        if (pop_fin) begin
            chk_head({tag, ".pophead"});
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            rd_ready = 1'b1;
        end
        if (clr_fin) begin
            exp_ovf   = 1'b0;
            clr_flags = 1'b1;
        end
        if (exp_q.size() < DEPTH) exp_q.push_back('{lat, m});
        else exp_ovf = 1'b1;
        @(negedge clk);
        dec_finish = 1'b0;
        rd_ready   = 1'b0;
        clr_flags  = 1'b0;
        chk({tag, ".busy0"}, 64'(busy), 64'd0);
        chk({tag, ".count"}, 64'(count), 64'(exp_q.size()));
        chk({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
    endtask

    initial begin
        rst = 1'b1; dec_start = 1'b0; dec_finish = 1'b0; dec_m = 16'd0;
        clr_flags = 1'b0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.valid", 64'(rd_valid), 64'd0);
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.ovf", 64'(overflow), 64'd0);
        chk("rst.tmo", 64'(timeout), 64'd0);

        // Single 100-cycle measurement, message 89
        measure(100, 16'd89, 1'b0, 1'b0, "lat100");
        drain_one("lat100.pop");
        chk_head("lat100.empty");

        // Three back-to-back measurements, then in-order drain
        measure(5, 16'd1, 1'b0, 1'b0, "b2b5");
        measure(7, 16'd2, 1'b0, 1'b0, "b2b7");
        measure(9, 16'd3, 1'b0, 1'b0, "b2b9");
        chk("b2b.count3", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) drain_one("b2b.pop");
        chk_head("b2b.empty");

        // DEPTH+1 measurements: last one dropped, head unchanged
        for (int i = 0; i <= DEPTH; i++) measure(3 + i, 16'(16'h10 + i), 1'b0, 1'b0, "ovf");
        chk("ovf.count", 64'(count), 64'(DEPTH));
        chk("ovf.flag", 64'(overflow), 64'd1);
        chk_head("ovf.head");
        clr_flags = 1'b1; exp_ovf = 1'b0;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("ovf.clr", 64'(overflow), 64'd0);

        // Full FIFO, clr_flags coincident with a refused push: set wins
        measure(6, 16'h0bad, 1'b0, 1'b1, "setwins");
        chk("setwins.head_same", 64'(rd_cycles), 64'd3);
        clr_flags = 1'b1; exp_ovf = 1'b0;
        @(negedge clk);
        clr_flags = 1'b0;

        // Full FIFO, finish with a pop in the same cycle: accepted
        measure(11, 16'h00aa, 1'b1, 1'b0, "fullpop");
        for (int i = 0; i < DEPTH; i++) drain_one("fullpop.drain");
        chk_head("fullpop.empty");

        // Finish while idle is ignored
        dec_finish = 1'b1; dec_m = 16'h7777;
        @(negedge clk);
        dec_finish = 1'b0;
        chk("idlefin.count", 64'(count), 64'd0);
        chk("idlefin.busy", 64'(busy), 64'd0);

        // Extra start mid-measurement and start coincident with finish
        dec_start = 1'b1;
        @(negedge clk);
        dec_start = 1'b0;
        repeat (3) @(negedge clk);
        dec_start = 1'b1;
        @(negedge clk);
        dec_start = 1'b0;
        repeat (5) @(negedge clk);
        dec_start = 1'b1; dec_finish = 1'b1; dec_m = 16'h0055;
        exp_q.push_back('{10, 16'h0055});
        @(negedge clk);
        dec_start = 1'b0; dec_finish = 1'b0;
        chk("restart.busy", 64'(busy), 64'd0);
        chk("restart.count", 64'(count), 64'd1);
        drain_one("restart.pop");

        // Timeout: start with no finish
        dec_start = 1'b1;
        @(negedge clk);
        dec_start = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("tmo.busy_before", 64'(busy), 64'd1);
        chk("tmo.flag_before", 64'(timeout), 64'd0);
        @(negedge clk);
        chk("tmo.busy", 64'(busy), 64'd0);
        chk("tmo.flag", 64'(timeout), 64'd1);
        chk("tmo.count", 64'(count), 64'd0);
        repeat (2) @(negedge clk);
        dec_finish = 1'b1;
        @(negedge clk);
        dec_finish = 1'b0;
        chk("tmo.latefin", 64'(count), 64'd0);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("tmo.clr", 64'(timeout), 64'd0);

        // Reset mid-measurement, finish afterwards
        dec_start = 1'b1;
        @(negedge clk);
        dec_start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        dec_finish = 1'b1;
        @(negedge clk);
        dec_finish = 1'b0;
        chk("rstmid.count", 64'(count), 64'd0);
        chk("rstmid.valid", 64'(rd_valid), 64'd0);
        chk("rstmid.busy", 64'(busy), 64'd0);
        chk("rstmid.ovf", 64'(overflow), 64'd0);
        chk("rstmid.tmo", 64'(timeout), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
